// File: rtl/des_tables_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_tables_pkg
//  Description : Shared DES bit-selection tables. Each entry holds the
//                1-based source-bit number reduced modulo 64 into 6 bits,
//                so source bit 64 is stored as 0.
//  Revision    : 1.0 - initial release (IP, PC1)
// ============================================================================
package des_tables_pkg;

   localparam int IP_LEN  = 64;
   localparam int PC1_LEN = 56;

   localparam int TABLE_IP  = 0;
   localparam int TABLE_PC1 = 1;

   // Initial permutation, index 0 first; index 24 is source bit 64 -> 0.
   localparam logic [5:0] IP_TABLE [IP_LEN] = '{
      6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
      6'd60, 6'd52, 6'd44, 6'd36, 6'd28, 6'd20, 6'd12, 6'd4,
      6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14, 6'd6,
      6'd0,  6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,
      6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
      6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
      6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,
      6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7
   };

   // Permuted choice 1, index 0 first; parity bits (multiples of 8) absent.
   localparam logic [5:0] PC1_TABLE [PC1_LEN] = '{
      6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
      6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
      6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
      6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
      6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
      6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
      6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
      6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
   };

   // Entry lookup for the selected table; indices past the end return 0.
   function automatic logic [5:0] table_lookup(input int sel, input logic [5:0] idx);
      logic [5:0] val;
      val = 6'd0;
      if (sel == TABLE_IP) begin
         val = IP_TABLE[idx];
      end else if (idx < 6'(PC1_LEN)) begin
         val = PC1_TABLE[idx];
      end
      return val;
   endfunction

endpackage
`default_nettype wire

// File: rtl/des_perm_table_rom.sv
`default_nettype none
// ============================================================================
//  Module      : des_perm_table_rom
//  Description : Single-read-port synchronous ROM holding one DES
//                bit-selection table (IP or PC1, chosen by TABLE_SEL).
//                One-cycle read latency, output held while ce0 is low,
//                out-of-range reads return 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_perm_table_rom
   import des_tables_pkg::*;
#(
   parameter int TABLE_SEL    = 0,
   parameter int DataWidth    = 6,
   parameter int AddressRange = 64,
   parameter int AddressWidth = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [AddressWidth-1:0] address0,
   input  logic                    ce0,
   output logic [DataWidth-1:0]    q0
);

   // Entry width and address width are tied to the 6-bit modulo-64 encoding,
   // and the entry count must match the chosen table exactly.
   localparam bit PARAMS_OK =
      ((TABLE_SEL == TABLE_IP  && AddressRange == IP_LEN) ||
       (TABLE_SEL == TABLE_PC1 && AddressRange == PC1_LEN)) &&
      (DataWidth == 6) && (AddressWidth == 6);

   localparam logic [AddressWidth:0] RANGE_LIMIT = AddressRange[AddressWidth:0];

   generate
      if (!PARAMS_OK) begin : g_bad_params
         $error("des_perm_table_rom: unsupported TABLE_SEL/DataWidth/AddressRange/AddressWidth");
      end
   endgenerate

   logic [DataWidth-1:0] q0_d;
   logic [DataWidth-1:0] q0_q;
   logic                 w_in_range;
   logic [DataWidth-1:0] w_entry;

   // Address decode: table contents for the presented index, zero when past the end.
   always_comb begin
      w_in_range = ({1'b0, address0} < RANGE_LIMIT);
      w_entry    = w_in_range ? table_lookup(TABLE_SEL, address0) : '0;
   end

   // Next output: load on read enable, otherwise hold.
   always_comb begin
      q0_d = q0_q;
      if (ce0) begin
         q0_d = w_entry;
      end
   end

   // Output register; reset clears it immediately, without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q0_q <= '0;
      end else begin
         q0_q <= q0_d;
      end
   end

   assign q0 = q0_q;

endmodule
`default_nettype wire

// File: tb/tb_des_perm_table_rom.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_perm_table_rom
//  Description : Self-checking bench for both IP and PC1 ROM instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_des_perm_table_rom;

   logic       clk = 1'b0;
   logic       reset;
   logic       ce0;
   logic [5:0] address0;
   logic [5:0] q_ip;
   logic [5:0] q_pc;

   always #5 clk = ~clk;

   des_perm_table_rom #(
      .TABLE_SEL(0), .DataWidth(6), .AddressRange(64), .AddressWidth(6)
   ) u_ip (
      .clk(clk), .reset(reset), .address0(address0), .ce0(ce0), .q0(q_ip)
   );

   des_perm_table_rom #(
      .TABLE_SEL(1), .DataWidth(6), .AddressRange(56), .AddressWidth(6)
   ) u_pc1 (
      .clk(clk), .reset(reset), .address0(address0), .ce0(ce0), .q0(q_pc)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [5:0] exp_ip = 6'd0;
   logic [5:0] exp_pc = 6'd0;

   typedef struct {
      bit         sel;
      logic [5:0] addr;
      logic [5:0] exp;
   } vec_t;

   // Reference entries generated from the column structure of the FIPS tables.
   function automatic logic [5:0] ref_entry(input int sel, input int idx);
      int r, c, k, v;
      v = 0;
      if (sel == 0) begin
         if (idx < 64) begin
            r = idx / 8;
            c = idx % 8;
            v = (r < 4) ? (58 + 2 * r - 8 * c) : (57 + 2 * (r - 4) - 8 * c);
         end
      end else if (idx < 56) begin
         if (idx < 28) begin
            k = idx;
            v = 57 + k / 8 - 8 * (k % 8);
         end else begin
            k = idx - 28;
            v = (k < 24) ? (63 - k / 8 - 8 * (k % 8)) : (28 - 8 * (k - 24));
         end
      end
      return 6'(v % 64);
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance one clock, updating the model from the inputs seen at the edge.
   task automatic tick();
      logic [5:0] nip, npc;
      nip = exp_ip;
      npc = exp_pc;
      if (reset) begin
         nip = 6'd0;
         npc = 6'd0;
      end else if (ce0) begin
         nip = ref_entry(0, int'(address0));
         npc = ref_entry(1, int'(address0));
      end
      @(posedge clk);
      #1;
      exp_ip = nip;
      exp_pc = npc;
   endtask

   vec_t vecs[12];
   logic [63:0] seen_ip, seen_pc, want_pc;

   initial begin
      vecs[0]  = '{1'b0, 6'd0,  6'd58};
      vecs[1]  = '{1'b0, 6'd7,  6'd2};
      vecs[2]  = '{1'b0, 6'd24, 6'd0};
      vecs[3]  = '{1'b0, 6'd63, 6'd7};
      vecs[4]  = '{1'b1, 6'd0,  6'd57};
      vecs[5]  = '{1'b1, 6'd7,  6'd1};
      vecs[6]  = '{1'b1, 6'd28, 6'd63};
      vecs[7]  = '{1'b1, 6'd55, 6'd4};
      vecs[8]  = '{1'b1, 6'd56, 6'd0};
      vecs[9]  = '{1'b1, 6'd63, 6'd0};
      vecs[10] = '{1'b0, 6'd8,  6'd60};
      vecs[11] = '{1'b0, 6'd1,  6'd50};

      reset    = 1'b1;
      ce0      = 1'b0;
      address0 = 6'd0;
      tick();
      tick();
      check("reset_ip", q_ip, 6'd0);
      check("reset_pc1", q_pc, 6'd0);
      reset = 1'b0;
      tick();

      // Latency: nothing visible before the sampling edge.
      address0 = 6'd0;
      ce0      = 1'b1;
      #2;
      check("latency_ip_pre_edge", q_ip, 6'd0);
      tick();
      check("latency_ip_post_edge", q_ip, 6'd58);

      // Table vectors, applied back to back.
      for (int i = 0; i < 12; i++) begin
         address0 = vecs[i].addr;
         ce0      = 1'b1;
         tick();
         check($sformatf("vec%0d_%s_addr%0d", i, vecs[i].sel ? "pc1" : "ip", vecs[i].addr),
               vecs[i].sel ? q_pc : q_ip, vecs[i].exp);
      end

      // Hold with ce0 low while the address wanders.
      address0 = 6'd8;
      ce0      = 1'b1;
      tick();
      check("hold_load", q_ip, 6'd60);
      ce0 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         address0 = 6'($urandom_range(0, 63));
         tick();
         check($sformatf("hold_cycle%0d", i), q_ip, 6'd60);
      end

      // Asynchronous reset between edges, then reset beating ce0.
      address0 = 6'd0;
      ce0      = 1'b1;
      tick();
      check("pre_async_reset", q_ip, 6'd58);
      #2;
      reset  = 1'b1;
      exp_ip = 6'd0;
      exp_pc = 6'd0;
      #1;
      check("async_reset_ip", q_ip, 6'd0);
      check("async_reset_pc1", q_pc, 6'd0);
      address0 = 6'd5;
      tick();
      check("reset_wins_over_ce0", q_ip, 6'd0);
      reset    = 1'b0;
      address0 = 6'd1;
      tick();
      check("post_reset_read", q_ip, 6'd50);

      // Full sweep of both instances plus permutation-set checks.
      seen_ip = '0;
      seen_pc = '0;
      want_pc = '0;
      for (int v = 1; v <= 64; v++) begin
         if (v % 8 != 0) want_pc[v % 64] = 1'b1;
      end
      for (int a = 0; a < 64; a++) begin
         address0 = 6'(a);
         ce0      = 1'b1;
         tick();
         check($sformatf("sweep_ip_%0d", a), q_ip, ref_entry(0, a));
         check($sformatf("sweep_pc1_%0d", a), q_pc, ref_entry(1, a));
         seen_ip[q_ip] = 1'b1;
         if (a < 56) seen_pc[q_pc] = 1'b1;
      end
      n_tests++;
      if (seen_ip !== {64{1'b1}}) begin
         n_fail++;
         $display("FAIL ip_set: got %h, expected %h", seen_ip, {64{1'b1}});
      end
      n_tests++;
      if (seen_pc !== want_pc) begin
         n_fail++;
         $display("FAIL pc1_set: got %h, expected %h", seen_pc, want_pc);
      end

      // Randomized traffic against the model, including occasional resets.
      for (int i = 0; i < 400; i++) begin
         reset    = ($urandom_range(0, 99) < 4);
         ce0      = $urandom_range(0, 1) == 1;
         address0 = 6'($urandom_range(0, 63));
         tick();
         check($sformatf("rand%0d_ip", i), q_ip, exp_ip);
         check($sformatf("rand%0d_pc1", i), q_pc, exp_pc);
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
